// File: rtl/bus_defs.sv
// Shared definitions for the peripheral bus bridge: FSM encodings,
// default error data and the slot-select field position.
package bus_defs;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_RESPOND = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic [31:0] ERROR_DATA_DEF = 32'hDEADBEEF;

    localparam int SLOT_LSB = 24;
    localparam int SLOT_MSB = 25;
    localparam int SLOT_W   = SLOT_MSB - SLOT_LSB + 1;

endpackage

// File: rtl/periph_addr_decoder.sv
// Combinational slot decoder: slot field to one-hot select,
// flagging slots beyond the populated range.
module periph_addr_decoder
    import bus_defs::*;
#(
    parameter int NUM_SLAVES = 4
) (
    input  logic [SLOT_W-1:0]     slot_i,
    output logic [NUM_SLAVES-1:0] sel_o,
    output logic                  err_o
);

    always_comb begin
        sel_o = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_o[i] = (int'(slot_i) == i);
        end
        err_o = (int'(slot_i) >= NUM_SLAVES);
    end

endmodule

// File: rtl/peripheral_bus_bridge.sv
// Single-master to NUM_SLAVES peripheral bridge, one transaction at a time.
// Optional ACCESS watchdog enabled by defining PERIPH_TIMEOUT_EN.
module peripheral_bus_bridge
    import bus_defs::*;
#(
    parameter int          NUM_SLAVES     = 4,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERROR_DATA     = ERROR_DATA_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     peripheral_read_request,
    input  logic                     peripheral_write_request,
    input  logic [31:0]              peripheral_addr,
    input  logic [31:0]              peripheral_write_data,
    output logic [31:0]              peripheral_read_data,
    output logic                     peripheral_response,
    output logic [NUM_SLAVES-1:0]    slave_read_request,
    output logic [NUM_SLAVES-1:0]    slave_write_request,
    output logic [31:0]              slave_addr,
    output logic [31:0]              slave_write_data,
    input  logic [NUM_SLAVES*32-1:0] slave_read_data,
    input  logic [NUM_SLAVES-1:0]    slave_response,
    output logic                     bus_error
);

    logic [1:0]            state_q, state_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  wr_q, wr_d;
    logic                  resp_q, resp_d;
    logic                  berr_q, berr_d;
    logic [NUM_SLAVES-1:0] rreq_q, rreq_d;
    logic [NUM_SLAVES-1:0] wreq_q, wreq_d;

    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  dec_err;
    logic [31:0]           sel_rdata;
    logic                  hit;
    logic                  expired;

    periph_addr_decoder #(
        .NUM_SLAVES(NUM_SLAVES)
    ) u_dec (
        .slot_i(peripheral_addr[SLOT_MSB:SLOT_LSB]),
        .sel_o (dec_sel),
        .err_o (dec_err)
    );

    // Only the slot currently strobed may complete the access.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (rreq_q[i] || wreq_q[i]) begin
                sel_rdata = slave_read_data[32*i +: 32];
            end
        end
        hit = |((rreq_q | wreq_q) & slave_response);
    end

`ifdef PERIPH_TIMEOUT_EN
    localparam int CLOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W  = (CLOG_W > 8) ? CLOG_W : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired = (state_q == ST_ACCESS)
                  && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter rests at zero outside ACCESS, so each access starts fresh.
    always_comb begin
        cnt_d = '0;
        if (state_q == ST_ACCESS && !hit && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rreq_d  = rreq_q;
        wreq_d  = wreq_q;
        resp_d  = 1'b0;
        berr_d  = 1'b0;
        rdata_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (peripheral_read_request || peripheral_write_request) begin
                    addr_d  = peripheral_addr;
                    wdata_d = peripheral_write_data;
                    wr_d    = peripheral_write_request;
                    if (dec_err) begin
                        state_d = ST_RESPOND;
                        resp_d  = 1'b1;
                        berr_d  = 1'b1;
                        rdata_d = peripheral_write_request ? '0 : ERROR_DATA;
                    end else begin
                        state_d = ST_ACCESS;
                        wreq_d  = peripheral_write_request ? dec_sel : '0;
                        rreq_d  = peripheral_write_request ? '0 : dec_sel;
                    end
                end
            end
            ST_ACCESS: begin
                if (hit) begin
                    state_d = ST_RESPOND;
                    rreq_d  = '0;
                    wreq_d  = '0;
                    resp_d  = 1'b1;
                    rdata_d = wr_q ? '0 : sel_rdata;
                end else if (expired) begin
                    state_d = ST_RESPOND;
                    rreq_d  = '0;
                    wreq_d  = '0;
                    resp_d  = 1'b1;
                    berr_d  = 1'b1;
                    rdata_d = wr_q ? '0 : ERROR_DATA;
                end
            end
            ST_RESPOND: state_d = ST_RELEASE;
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            resp_q  <= 1'b0;
            berr_q  <= 1'b0;
            rreq_q  <= '0;
            wreq_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            resp_q  <= resp_d;
            berr_q  <= berr_d;
            rreq_q  <= rreq_d;
            wreq_q  <= wreq_d;
        end
    end

    assign peripheral_read_data = rdata_q;
    assign peripheral_response  = resp_q;
    assign bus_error            = berr_q;
    assign slave_read_request   = rreq_q;
    assign slave_write_request  = wreq_q;
    assign slave_addr           = addr_q;
    assign slave_write_data     = wdata_q;

endmodule

// File: tb/tb_peripheral_bus_bridge.sv
// Directed bench for peripheral_bus_bridge (3 slots, 8-cycle timeout).
// Timeout checks apply when PERIPH_TIMEOUT_EN is defined.
module tb_peripheral_bus_bridge;

    localparam int NS = 3;

    logic          clk;
    logic          rst_n;
    logic          peripheral_read_request;
    logic          peripheral_write_request;
    logic [31:0]   peripheral_addr;
    logic [31:0]   peripheral_write_data;
    logic [31:0]   peripheral_read_data;
    logic          peripheral_response;
    logic [NS-1:0] slave_read_request;
    logic [NS-1:0] slave_write_request;
    logic [31:0]   slave_addr;
    logic [31:0]   slave_write_data;
    logic [NS*32-1:0] slave_read_data;
    logic [NS-1:0] slave_response;
    logic          bus_error;

    int checks;
    int errors;

    peripheral_bus_bridge #(
        .NUM_SLAVES    (NS),
        .TIMEOUT_CYCLES(8),
        .ERROR_DATA    (32'hDEADBEEF)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .peripheral_read_request (peripheral_read_request),
        .peripheral_write_request(peripheral_write_request),
        .peripheral_addr         (peripheral_addr),
        .peripheral_write_data   (peripheral_write_data),
        .peripheral_read_data    (peripheral_read_data),
        .peripheral_response     (peripheral_response),
        .slave_read_request      (slave_read_request),
        .slave_write_request     (slave_write_request),
        .slave_addr              (slave_addr),
        .slave_write_data        (slave_write_data),
        .slave_read_data         (slave_read_data),
        .slave_response          (slave_response),
        .bus_error               (bus_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        peripheral_read_request  = 1'b0;
        peripheral_write_request = 1'b0;
        slave_response           = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        peripheral_addr       = 32'h8100_0000;
        peripheral_write_data = 32'h5555_5555;
        slave_read_data       = '0;
        step();
        step();
        checks++;
        if (peripheral_response !== 1'b0 || bus_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp got resp=%b err=%b want 0 0",
                     peripheral_response, bus_error);
        end
        checks++;
        if (peripheral_read_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h want 0", peripheral_read_data);
        end
        checks++;
        if (slave_read_request !== '0 || slave_write_request !== '0) begin
            errors++;
            $display("FAIL reset_strobe got r=%b w=%b want 0 0",
                     slave_read_request, slave_write_request);
        end
        checks++;
        if (slave_addr !== 32'h0 || slave_write_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs got a=%h d=%h want 0 0",
                     slave_addr, slave_write_data);
        end
        rst_n = 1'b1;
        step();
        // Stray slave responses while idle must be ignored.
        slave_response = 3'b111;
        step();
        step();
        checks++;
        if (peripheral_response !== 1'b0 || slave_read_request !== '0) begin
            errors++;
            $display("FAIL idle_stray got resp=%b strb=%b want 0 000",
                     peripheral_response, slave_read_request);
        end
        slave_response = '0;
        step();
    endtask

    task automatic test_read_slot1();
        peripheral_addr         = 32'h8100_0004;
        peripheral_read_request = 1'b1;
        step();
        checks++;
        if (slave_read_request !== 3'b010 || slave_write_request !== 3'b000) begin
            errors++;
            $display("FAIL rd1_strobe got r=%b w=%b want 010 000",
                     slave_read_request, slave_write_request);
        end
        checks++;
        if (slave_addr !== 32'h8100_0004) begin
            errors++;
            $display("FAIL rd1_addr got %h want 81000004", slave_addr);
        end
        slave_response                = 3'b001;
        slave_read_data[0 +: 32]      = 32'hBAD0_BAD0;
        step();
        slave_response = 3'b000;
        step();
        checks++;
        if (slave_read_request !== 3'b010 || peripheral_response !== 1'b0) begin
            errors++;
            $display("FAIL rd1_wrong_slot got strb=%b resp=%b want 010 0",
                     slave_read_request, peripheral_response);
        end
        slave_response           = 3'b010;
        slave_read_data[32 +: 32] = 32'h1234_5678;
        step();
        slave_response = 3'b000;
        checks++;
        if (peripheral_response !== 1'b1 || bus_error !== 1'b0) begin
            errors++;
            $display("FAIL rd1_resp got resp=%b err=%b want 1 0",
                     peripheral_response, bus_error);
        end
        checks++;
        if (peripheral_read_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rd1_data got %h want 12345678", peripheral_read_data);
        end
        checks++;
        if (slave_read_request !== 3'b000) begin
            errors++;
            $display("FAIL rd1_strobe_drop got %b want 000", slave_read_request);
        end
        peripheral_read_request = 1'b0;
        step();
        checks++;
        if (peripheral_response !== 1'b0 || peripheral_read_data !== 32'h0) begin
            errors++;
            $display("FAIL rd1_pulse got resp=%b data=%h want 0 0",
                     peripheral_response, peripheral_read_data);
        end
        step();
    endtask

    task automatic test_write_priority();
        peripheral_addr          = 32'h8000_0000;
        peripheral_write_data    = 32'hA5A5_A5A5;
        peripheral_read_request  = 1'b1;
        peripheral_write_request = 1'b1;
        step();
        checks++;
        if (slave_write_request !== 3'b001 || slave_read_request !== 3'b000) begin
            errors++;
            $display("FAIL wr_strobe got w=%b r=%b want 001 000",
                     slave_write_request, slave_read_request);
        end
        checks++;
        if (slave_write_data !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL wr_data got %h want a5a5a5a5", slave_write_data);
        end
        slave_read_data[0 +: 32] = 32'hFFFF_FFFF;
        slave_response           = 3'b001;
        step();
        slave_response = 3'b000;
        checks++;
        if (peripheral_response !== 1'b1 || peripheral_read_data !== 32'h0) begin
            errors++;
            $display("FAIL wr_resp got resp=%b data=%h want 1 0",
                     peripheral_response, peripheral_read_data);
        end
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_out_of_range();
        peripheral_addr         = 32'h8300_0000;
        peripheral_read_request = 1'b1;
        step();
        checks++;
        if (peripheral_response !== 1'b1 || bus_error !== 1'b1) begin
            errors++;
            $display("FAIL oor_rd_resp got resp=%b err=%b want 1 1",
                     peripheral_response, bus_error);
        end
        checks++;
        if (peripheral_read_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL oor_rd_data got %h want deadbeef", peripheral_read_data);
        end
        checks++;
        if (slave_read_request !== '0 || slave_write_request !== '0) begin
            errors++;
            $display("FAIL oor_no_strobe got r=%b w=%b want 000 000",
                     slave_read_request, slave_write_request);
        end
        peripheral_read_request = 1'b0;
        step();
        checks++;
        if (bus_error !== 1'b0 || peripheral_response !== 1'b0) begin
            errors++;
            $display("FAIL oor_pulse got err=%b resp=%b want 0 0",
                     bus_error, peripheral_response);
        end
        step();
        peripheral_write_request = 1'b1;
        peripheral_write_data    = 32'h0101_0101;
        step();
        checks++;
        if (bus_error !== 1'b1 || peripheral_read_data !== 32'h0) begin
            errors++;
            $display("FAIL oor_wr got err=%b data=%h want 1 0",
                     bus_error, peripheral_read_data);
        end
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_held_request();
        int nstrobe;
        int nresp;
        nstrobe = 0;
        nresp   = 0;
        peripheral_addr         = 32'h8200_0010;
        peripheral_read_request = 1'b1;
        step();
        if (slave_read_request != 0) nstrobe++;
        slave_read_data[64 +: 32] = 32'hCAFE_F00D;
        slave_response            = 3'b100;
        step();
        slave_response = 3'b000;
        checks++;
        if (peripheral_read_data !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL held_data got %h want cafef00d", peripheral_read_data);
        end
        for (int c = 0; c < 4; c++) begin
            if (slave_read_request != 0) nstrobe++;
            if (peripheral_response) nresp++;
            if (c == 2) peripheral_read_request = 1'b0;
            step();
        end
        checks++;
        if (nstrobe !== 1 || nresp !== 1) begin
            errors++;
            $display("FAIL held_once got strobes=%0d resps=%0d want 1 1",
                     nstrobe, nresp);
        end
        step();
    endtask

    task automatic test_timeout();
        int hi;
        peripheral_addr         = 32'h8000_0020;
        peripheral_read_request = 1'b1;
        step();
        hi = 0;
`ifdef PERIPH_TIMEOUT_EN
        for (int c = 0; c < 8; c++) begin
            if (slave_read_request == 3'b001) hi++;
            step();
        end
        checks++;
        if (hi !== 8 || slave_read_request !== 3'b000) begin
            errors++;
            $display("FAIL to_strobe got cycles=%0d now=%b want 8 000",
                     hi, slave_read_request);
        end
        checks++;
        if (peripheral_response !== 1'b1 || bus_error !== 1'b1
            || peripheral_read_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL to_resp got resp=%b err=%b data=%h want 1 1 deadbeef",
                     peripheral_response, bus_error, peripheral_read_data);
        end
        peripheral_read_request = 1'b0;
        step();
        step();
        peripheral_read_request = 1'b1;
        step();
        for (int c = 0; c < 7; c++) step();
        slave_read_data[0 +: 32] = 32'h600D_DA7A;
        slave_response           = 3'b001;
        step();
        slave_response = 3'b000;
        checks++;
        if (peripheral_response !== 1'b1 || bus_error !== 1'b0
            || peripheral_read_data !== 32'h600D_DA7A) begin
            errors++;
            $display("FAIL to_race got resp=%b err=%b data=%h want 1 0 600dda7a",
                     peripheral_response, bus_error, peripheral_read_data);
        end
`else
        for (int c = 0; c < 20; c++) begin
            if (slave_read_request == 3'b001 && !peripheral_response) hi++;
            step();
        end
        checks++;
        if (hi !== 20 || slave_read_request !== 3'b001) begin
            errors++;
            $display("FAIL wait_strobe got cycles=%0d now=%b want 20 001",
                     hi, slave_read_request);
        end
        slave_read_data[0 +: 32] = 32'h600D_DA7A;
        slave_response           = 3'b001;
        step();
        slave_response = 3'b000;
        checks++;
        if (peripheral_response !== 1'b1 || bus_error !== 1'b0
            || peripheral_read_data !== 32'h600D_DA7A) begin
            errors++;
            $display("FAIL wait_resp got resp=%b err=%b data=%h want 1 0 600dda7a",
                     peripheral_response, bus_error, peripheral_read_data);
        end
`endif
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_reset_mid_access();
        peripheral_addr          = 32'h8100_0008;
        peripheral_write_data    = 32'h1122_3344;
        peripheral_write_request = 1'b1;
        step();
        checks++;
        if (slave_write_request !== 3'b010) begin
            errors++;
            $display("FAIL rst_mid_strobe got %b want 010", slave_write_request);
        end
        step();
        rst_n = 1'b0;
        step();
        checks++;
        if (slave_write_request !== 3'b000 || peripheral_response !== 1'b0
            || slave_addr !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_drop got w=%b resp=%b a=%h want 000 0 0",
                     slave_write_request, peripheral_response, slave_addr);
        end
        rst_n = 1'b1;
        idle_inputs();
        step();
        checks++;
        if (peripheral_response !== 1'b0 || slave_write_request !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_quiet got resp=%b w=%b want 0 000",
                     peripheral_response, slave_write_request);
        end
        peripheral_addr         = 32'h8000_0004;
        peripheral_read_request = 1'b1;
        step();
        checks++;
        if (slave_read_request !== 3'b001) begin
            errors++;
            $display("FAIL rst_next_strobe got %b want 001", slave_read_request);
        end
        slave_read_data[0 +: 32] = 32'h0000_00AA;
        slave_response           = 3'b001;
        step();
        slave_response = 3'b000;
        checks++;
        if (peripheral_response !== 1'b1 || peripheral_read_data !== 32'h0000_00AA) begin
            errors++;
            $display("FAIL rst_next_resp got resp=%b data=%h want 1 000000aa",
                     peripheral_response, peripheral_read_data);
        end
        idle_inputs();
        step();
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_read_slot1();
        test_write_priority();
        test_out_of_range();
        test_held_request();
        test_timeout();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
